// File: rtl/softex_pkg.sv
// Shared types and helpers for the SoftEx TCDM splitter.
package softex_pkg;

  // Per-lane view of the current upstream request.
  typedef struct packed {
    logic active;   // lane takes part in this transaction
    logic pending;  // lane still needs a downstream grant
    logic done;     // lane granted now or earlier, or not involved at all
  } lane_desc_t;

  // Width of a counter that must hold 0..max_outst inclusive.
  function automatic int unsigned credit_width(input int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/softex_tcdm_lane_fifo.sv
// Registered FIFO (no fall-through); data_o is the head entry, valid while !empty_o.
module softex_tcdm_lane_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array; only pointers and count decide what is valid.
  // NOTE: the data array is deliberately not reset -- emptiness comes from
  // the count, and resetting RAM-like storage blocks memory inference.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO like reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  push_while_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !clear_i));
`endif

endmodule

// File: rtl/softex_tcdm_splitter.sv
// Splits one wide TCDM master into MP narrow lanes with per-lane grant tracking,
// per-lane response re-alignment and a credit limit on outstanding reads.
module softex_tcdm_splitter
  import softex_pkg::*;
#(
  parameter int unsigned MP         = 4,
  parameter int unsigned PORT_DW    = 64,
  parameter int unsigned AW         = 32,
  parameter int unsigned IW         = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      up_req_i,
  output logic                      up_gnt_o,
  input  logic [AW-1:0]             up_add_i,
  input  logic                      up_wen_i,
  input  logic [MP*PORT_DW/8-1:0]   up_be_i,
  input  logic [MP*PORT_DW-1:0]     up_data_i,
  input  logic [IW-1:0]             up_id_i,
  output logic                      up_r_valid_o,
  input  logic                      up_r_ready_i,
  output logic [MP*PORT_DW-1:0]     up_r_data_o,
  output logic [IW-1:0]             up_r_id_o,
  output logic [MP-1:0]             dn_req_o,
  input  logic [MP-1:0]             dn_gnt_i,
  output logic [MP*AW-1:0]          dn_add_o,
  output logic [MP-1:0]             dn_wen_o,
  output logic [MP*PORT_DW/8-1:0]   dn_be_o,
  output logic [MP*PORT_DW-1:0]     dn_data_o,
  output logic [MP*IW-1:0]          dn_id_o,
  input  logic [MP-1:0]             dn_r_valid_i,
  output logic [MP-1:0]             dn_r_ready_o,
  input  logic [MP*PORT_DW-1:0]     dn_r_data_i,
  output logic                      busy_o
);

  localparam int unsigned BW = PORT_DW / 8;
  localparam int unsigned CW = credit_width(MAX_OUTST);

  lane_desc_t [MP-1:0]   lane;
  logic [MP-1:0]         lane_done;
  logic [MP-1:0]         granted_q;
  logic [CW-1:0]         outst_q;
  logic                  live;
  logic                  credit_ok;
  logic                  issue;
  logic                  up_gnt;
  logic                  rd_issue;
  logic                  rsp_hs;
  logic [MP-1:0]         fifo_full;
  logic [MP-1:0]         fifo_empty;
  logic [MP*PORT_DW-1:0] fifo_head;
  logic [IW-1:0]         id_head;
  logic                  id_full;
  logic                  id_empty;

  // Reset and soft clear both freeze the request path so nothing is granted
  // while bookkeeping is being wiped.
  assign live      = rst_ni & ~clear_i;
  assign credit_ok = ~up_wen_i | ((outst_q < CW'(MAX_OUTST)) & ~id_full);
  assign issue     = live & up_req_i & credit_ok;

  // Lane participation and grant status for the request currently presented.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a bit unassigned and infer a latch.
  always_comb begin
    lane      = '0;
    lane_done = '0;
    for (int i = 0; i < MP; i++) begin
      lane[i].active  = up_wen_i | (|up_be_i[i*BW +: BW]);
      lane[i].pending = lane[i].active & ~granted_q[i];
      lane[i].done    = ~lane[i].pending | dn_gnt_i[i];
      lane_done[i]    = lane[i].done;
    end
  end

  assign up_gnt   = issue & (&lane_done);
  assign up_gnt_o = up_gnt;
  assign rd_issue = up_gnt & up_wen_i;

  for (genvar g = 0; g < MP; g++) begin : g_lane
    assign dn_req_o[g]                    = issue & lane[g].pending;
    assign dn_add_o[g*AW +: AW]           = dn_req_o[g] ? up_add_i + AW'(g * BW) : '0;
    assign dn_wen_o[g]                    = dn_req_o[g] & up_wen_i;
    assign dn_be_o[g*BW +: BW]            = dn_req_o[g] ? up_be_i[g*BW +: BW] : '0;
    assign dn_data_o[g*PORT_DW +: PORT_DW] = dn_req_o[g] ? up_data_i[g*PORT_DW +: PORT_DW] : '0;
    assign dn_id_o[g*IW +: IW]            = dn_req_o[g] ? up_id_i : '0;
    assign dn_r_ready_o[g]                = ~fifo_full[g];

    softex_tcdm_lane_fifo #(
      .DW    (PORT_DW),
      .DEPTH (FIFO_DEPTH)
    ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (dn_r_valid_i[g] & dn_r_ready_o[g]),
      .data_i  (dn_r_data_i[g*PORT_DW +: PORT_DW]),
      .pop_i   (rsp_hs),
      .data_o  (fifo_head[g*PORT_DW +: PORT_DW]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  // IDs of granted reads, returned in issue order alongside merged data.
  softex_tcdm_lane_fifo #(
    .DW    (IW),
    .DEPTH (MAX_OUTST)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (rd_issue),
    .data_i  (up_id_i),
    .pop_i   (rsp_hs),
    .data_o  (id_head),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

  // A merged response exists only once every lane has its beat queued.
  assign up_r_valid_o = ~(|fifo_empty) & ~id_empty;
  assign rsp_hs       = up_r_valid_o & up_r_ready_i;
  assign up_r_data_o  = up_r_valid_o ? fifo_head : '0;
  assign up_r_id_o    = up_r_valid_o ? id_head : '0;
  assign busy_o       = (outst_q != '0) | (|granted_q);

  // Partial-grant memory and read-credit counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      granted_q <= '0;
      outst_q   <= '0;
    end else if (clear_i) begin
      granted_q <= '0;
      outst_q   <= '0;
    end else begin
      if (up_gnt) granted_q <= '0;
      else        granted_q <= granted_q | (dn_req_o & dn_gnt_i);
      unique case ({rd_issue, rsp_hs})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule
